// File: rtl/uart_msg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_msg_pkg
//  Description : Shared types and default constants for the UART message
//                sender: FSM state encoding and default timing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_msg_pkg;

    // FSM state encoding for the message sender
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEF_PERIOD_CYC  = CLK_HZ / 2;   // 0.5 s
    localparam int DEF_TIMEOUT_CYC = 1_000_000;    // 20 ms

endpackage : uart_msg_pkg
`default_nettype wire

// File: rtl/uart_msg_buf.sv
`default_nettype none
// ============================================================================
//  Module      : uart_msg_buf
//  Description : DEPTH x DATA_W message buffer, single write port and a
//                registered read port. Writes are refused while the sender
//                is busy, and a refused write raises a one-cycle wr_err.
//  Ports       : clk_50MHz, uart_rst_p   - clock, async active-high reset
//                wr_en_i/wr_addr_i/wr_data_i - write port
//                busy_i                  - sender busy, blocks writes
//                rd_en_i/rd_addr_i       - read request (data next cycle)
//                rd_data_o               - registered read data
//                wr_err_o                - write attempted while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_50MHz,
    input  logic              uart_rst_p,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              busy_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              wr_err_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage is deliberately not reset so message content survives a reset.
    always_ff @(posedge clk_50MHz) begin
        if (wr_en_i && !busy_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read register is what drives para_data, so it holds its value
    // between reads and clears on reset.
    always_ff @(posedge clk_50MHz or posedge uart_rst_p) begin
        if (uart_rst_p) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
    assign wr_err_o  = wr_en_i && busy_i;

endmodule : uart_msg_buf
`default_nettype wire

// File: rtl/uart_msg_sender.sv
`default_nettype none
// ============================================================================
//  Module      : uart_msg_sender
//  Description : Streams a programmable message from a byte buffer into a
//                uart_txd style enable/data/done handshake. Triggered by a
//                start pulse or a periodic timer; per-byte tx_done timeout.
//  Ports       : clk_50MHz, uart_rst_p        - clock, async active-high reset
//                start, periodic_en, msg_len  - trigger control
//                wr_en, wr_addr, wr_data      - buffer write port
//                tx_done                      - byte finished (from uart_txd)
//                uart_tx_enable, para_data    - byte request (to uart_txd)
//                busy, msg_done, overrun, tx_err, wr_err - status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_sender
    import uart_msg_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int LEN_W       = $clog2(DEPTH) + 1,
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_50MHz,
    input  logic              uart_rst_p,
    input  logic              start,
    input  logic              periodic_en,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tx_done,
    output logic              uart_tx_enable,
    output logic [DATA_W-1:0] para_data,
    output logic              busy,
    output logic              msg_done,
    output logic              overrun,
    output logic              tx_err,
    output logic              wr_err
);

    localparam int PER_W = $clog2(PERIOD_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              per_tick;
    logic              trig;
    logic [LEN_W-1:0]  eff_len;
    logic              is_last;
    logic              rd_en;

    // ------------------------------------------------------------------
    // Trigger generation; the period counter free-runs even while busy
    // ------------------------------------------------------------------
    assign per_tick  = periodic_en && (per_cnt_q == PER_W'(PERIOD_CYC - 1));
    assign per_cnt_d = (!periodic_en || per_tick) ? '0 : per_cnt_q + PER_W'(1);
    assign trig      = start || per_tick;

    // Lengths beyond the buffer are clamped rather than wrapping the index.
    assign eff_len = (msg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : msg_len;
    assign is_last = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        len_d          = len_q;
        to_cnt_d       = to_cnt_q;
        rd_en          = 1'b0;
        uart_tx_enable = 1'b0;
        msg_done       = 1'b0;
        tx_err         = 1'b0;
        // Any trigger outside IDLE (DONE included) is dropped and flagged.
        overrun        = trig && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (trig && (eff_len != '0)) begin
                    len_d   = eff_len;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rd_en   = 1'b1;
                state_d = S_FIRE;
            end
            S_FIRE: begin
                uart_tx_enable = 1'b1;
                to_cnt_d       = '0;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                // A tx_done arriving on the timeout cycle still wins.
                if (tx_done) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    tx_err  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_DONE: begin
                msg_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge uart_rst_p) begin
        if (uart_rst_p) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            per_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            per_cnt_q <= per_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Message buffer
    // ------------------------------------------------------------------
    uart_msg_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_50MHz  (clk_50MHz),
        .uart_rst_p (uart_rst_p),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .busy_i     (busy),
        .rd_en_i    (rd_en),
        .rd_addr_i  (idx_q),
        .rd_data_o  (para_data),
        .wr_err_o   (wr_err)
    );

endmodule : uart_msg_sender
`default_nettype wire

// File: tb/tb_uart_msg_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_msg_sender
//  Description : Self-checking bench for uart_msg_sender. A uart_txd stand-in
//                answers each enable with tx_done after a programmable delay;
//                every observed event is logged with its cycle number and
//                compared against timings computed from the message rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_msg_sender;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 5;
    localparam int PERIOD = 100;
    localparam int TMO    = 50;

    logic              clk_50MHz = 1'b0;
    logic              uart_rst_p;
    logic              start;
    logic              periodic_en;
    logic [LEN_W-1:0]  msg_len;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              tx_done;
    logic              uart_tx_enable;
    logic [DATA_W-1:0] para_data;
    logic              busy;
    logic              msg_done;
    logic              overrun;
    logic              tx_err;
    logic              wr_err;

    uart_msg_sender #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_50MHz      (clk_50MHz),
        .uart_rst_p     (uart_rst_p),
        .start          (start),
        .periodic_en    (periodic_en),
        .msg_len        (msg_len),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .tx_done        (tx_done),
        .uart_tx_enable (uart_tx_enable),
        .para_data      (para_data),
        .busy           (busy),
        .msg_done       (msg_done),
        .overrun        (overrun),
        .tx_err         (tx_err),
        .wr_err         (wr_err)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    int cyc = 0;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference buffer content and event logs
    logic [7:0] ref_mem [DEPTH];
    int         en_cyc[$];
    logic [7:0] en_dat[$];
    int         done_q[$];
    int         ovr_q[$];
    int         terr_q[$];
    int         werr_q[$];

    int rsp_delay  = 10;
    int withhold_n = 0;   // 0 = answer every byte; n = never answer byte n
    int rsp_cd     = 0;

    // uart_txd stand-in and event monitor: drive tx_done at the falling
    // edge, then sample everything shortly before the next rising edge.
    always @(negedge clk_50MHz) begin
        tx_done = 1'b0;
        if (rsp_cd > 0) begin
            rsp_cd = rsp_cd - 1;
            if (rsp_cd == 0) tx_done = 1'b1;
        end
        #4;
        if (uart_rst_p) begin
            rsp_cd = 0;
        end else begin
            if (uart_tx_enable) begin
                en_cyc.push_back(cyc);
                en_dat.push_back(para_data);
                if (!(withhold_n != 0 && en_cyc.size() == withhold_n))
                    rsp_cd = rsp_delay;
            end
            if (msg_done) done_q.push_back(cyc);
            if (overrun)  ovr_q.push_back(cyc);
            if (tx_err)   terr_q.push_back(cyc);
            if (wr_err)   werr_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic clear_logs();
        en_cyc.delete(); en_dat.delete(); done_q.delete();
        ovr_q.delete();  terr_q.delete(); werr_q.delete();
    endtask

    task automatic write_buf(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        ref_mem[addr] = data;
        step(1);
        wr_en = 1'b0;
    endtask

    // Message triggered in cycle t: byte k enabled at t+2+k*(d+2),
    // msg_done one cycle after the last tx_done.
    function automatic int end_cyc(input int t, input int eff, input int d);
        return t + 2 + (eff - 1) * (d + 2) + d + 1;
    endfunction

    task automatic check_msg(input string tag, input int t, input int eff, input int d);
        chk($sformatf("%s n_en", tag), en_cyc.size(), eff);
        for (int k = 0; k < eff && k < en_cyc.size(); k++) begin
            chk($sformatf("%s en_cyc[%0d]", tag, k), en_cyc[k], t + 2 + k * (d + 2));
            chk($sformatf("%s data[%0d]", tag, k), en_dat[k], ref_mem[k]);
        end
        chk($sformatf("%s n_done", tag), done_q.size(), 1);
        if (done_q.size() > 0)
            chk($sformatf("%s done_cyc", tag), done_q[0], end_cyc(t, eff, d));
        chk($sformatf("%s n_txerr", tag), terr_q.size(), 0);
    endtask

    task automatic send(input string tag, input int len, input int d);
        int t;
        int eff;
        clear_logs();
        rsp_delay = d;
        eff       = (len > DEPTH) ? DEPTH : len;
        msg_len   = LEN_W'(len);
        start     = 1'b1;
        t         = cyc;
        step(1);
        start = 1'b0;
        step(end_cyc(t, eff, d) - t + 3);
        check_msg(tag, t, eff, d);
        chk($sformatf("%s n_ovr", tag), ovr_q.size(), 0);
        chk($sformatf("%s busy_after", tag), busy, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        string hello;
        int    t;
        int    dcyc;
        int    len;
        int    d;
        logic [7:0] nv;

        uart_rst_p  = 1'b1;
        start       = 1'b0;
        periodic_en = 1'b0;
        msg_len     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        tx_done     = 1'b0;
        step(3);
        uart_rst_p = 1'b0;
        step(1);

        // ---- reset state
        chk("rst tx_enable", uart_tx_enable, 0);
        chk("rst para_data", para_data, 0);
        chk("rst busy", busy, 0);
        chk("rst msg_done", msg_done, 0);
        chk("rst overrun", overrun, 0);
        chk("rst tx_err", tx_err, 0);
        chk("rst wr_err", wr_err, 0);

        // ---- Hello World
        hello = "Hello World!\n";
        for (int i = 0; i < hello.len(); i++) write_buf(i, hello[i]);
        send("hello", 13, 10);

        // ---- randomized content, lengths and response delays
        for (int it = 0; it < 5; it++) begin
            for (int a = 0; a < DEPTH; a++) write_buf(a, 8'($urandom));
            len = (it == 0) ? 20 : (it == 1) ? 1 : (it == 2) ? 16 : $urandom_range(1, 20);
            d   = $urandom_range(1, 20);
            send($sformatf("rand%0d", it), len, d);
        end

        // ---- write and trigger in the same cycle: new byte is sent
        clear_logs();
        rsp_delay = 7;
        nv        = ~ref_mem[0];
        msg_len   = LEN_W'(3);
        start     = 1'b1;
        t         = cyc;
        write_buf(0, nv);
        start = 1'b0;
        step(end_cyc(t, 3, 7) - t + 2);
        check_msg("wr_trig", t, 3, 7);

        // ---- periodic mode
        clear_logs();
        rsp_delay   = 10;
        msg_len     = LEN_W'(2);
        periodic_en = 1'b1;
        t           = cyc;
        step(330);
        periodic_en = 1'b0;
        step(5);
        chk("per n_en", en_cyc.size(), 6);
        for (int m = 0; m < 3; m++) begin
            for (int j = 0; j < 2; j++) begin
                if (2 * m + j < en_cyc.size()) begin
                    chk($sformatf("per en_cyc[%0d]", 2 * m + j), en_cyc[2 * m + j],
                        t + (PERIOD - 1) + m * PERIOD + 2 + j * 12);
                    chk($sformatf("per data[%0d]", 2 * m + j), en_dat[2 * m + j], ref_mem[j]);
                end
            end
        end
        chk("per n_done", done_q.size(), 3);
        chk("per n_ovr", ovr_q.size(), 0);

        // ---- overrun mid-message and on the DONE cycle, refused write
        clear_logs();
        rsp_delay = 10;
        msg_len   = LEN_W'(6);
        nv        = ~ref_mem[5];
        start     = 1'b1;
        t         = cyc;
        dcyc      = end_cyc(t, 6, 10);
        step(1);
        start = 1'b0;
        while (cyc < dcyc + 12) begin
            start   = (cyc == t + 5) || (cyc == dcyc);
            wr_en   = (cyc == t + 8);
            wr_addr = ADDR_W'(5);
            wr_data = nv;
            msg_len = LEN_W'(cyc[3:0]);   // must not disturb the latched length
            step(1);
        end
        start = 1'b0;
        wr_en = 1'b0;
        check_msg("ovr", t, 6, 10);
        chk("ovr n_ovr", ovr_q.size(), 2);
        if (ovr_q.size() == 2) begin
            chk("ovr ovr_cyc0", ovr_q[0], t + 5);
            chk("ovr ovr_cyc1", ovr_q[1], dcyc);
        end
        chk("ovr n_wrerr", werr_q.size(), 1);
        if (werr_q.size() == 1) chk("ovr wrerr_cyc", werr_q[0], t + 8);
        send("after_wrerr", 6, 4);

        // ---- per-byte timeout on byte 3
        clear_logs();
        rsp_delay  = 10;
        withhold_n = 3;
        msg_len    = LEN_W'(6);
        start      = 1'b1;
        t          = cyc;
        step(1);
        start = 1'b0;
        step(2 + 2 * 12 + TMO + 6);
        chk("tmo n_en", en_cyc.size(), 3);
        for (int k = 0; k < 3 && k < en_cyc.size(); k++)
            chk($sformatf("tmo data[%0d]", k), en_dat[k], ref_mem[k]);
        chk("tmo n_txerr", terr_q.size(), 1);
        if (terr_q.size() > 0) chk("tmo txerr_cyc", terr_q[0], t + 2 + 2 * 12 + TMO);
        chk("tmo n_done", done_q.size(), 0);
        chk("tmo busy", busy, 0);
        withhold_n = 0;
        send("after_tmo", 4, 10);

        // ---- zero length: no activity at all
        clear_logs();
        msg_len = '0;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        chk("zero busy", busy, 0);
        step(20);
        chk("zero n_en", en_cyc.size(), 0);
        chk("zero n_done", done_q.size(), 0);
        chk("zero n_ovr", ovr_q.size(), 0);

        // ---- asynchronous reset while waiting for tx_done
        clear_logs();
        rsp_delay = 10;
        msg_len   = LEN_W'(5);
        start     = 1'b1;
        step(1);
        start = 1'b0;
        step(2 + 12 + 3);
        chk("prerst busy", busy, 1);
        #1;
        uart_rst_p = 1'b1;
        #1;
        chk("midrst tx_enable", uart_tx_enable, 0);
        chk("midrst para_data", para_data, 0);
        chk("midrst busy", busy, 0);
        chk("midrst msg_done", msg_done, 0);
        chk("midrst tx_err", tx_err, 0);
        step(2);
        uart_rst_p = 1'b0;
        step(15);
        chk("postrst n_done", done_q.size(), 0);
        chk("postrst n_txerr", terr_q.size(), 0);
        send("after_rst", 5, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_msg_sender
`default_nettype wire

// File: doc/uart_msg_sender.md
Name: uart_msg_sender

Overview:
- Parametrised message transmitter between user logic and uart_txd.
- Holds a writable byte buffer of DEPTH entries.
- On a start pulse, or on an internal periodic timer, streams msg_len bytes through the uart_txd enable/data/done handshake, one byte per tx_done.
- Adds runtime-programmable message content and length, single-shot or periodic mode, a per-byte timeout, and overrun/error reporting.

Parameters:
DATA_W, 8, byte width of buffer entries and para_data
DEPTH, 16, buffer depth in bytes; power of 2, minimum 2
ADDR_W, $clog2(DEPTH), buffer address width (derived; do not override)
LEN_W, $clog2(DEPTH)+1, msg_len width, so that DEPTH itself is representable (derived)
PERIOD_CYC, 25_000_000, periodic trigger interval in clk_50MHz cycles (0.5 s)
TIMEOUT_CYC, 1_000_000, maximum cycles to wait for tx_done per byte before abort

Ports:
clk_50MHz  in  1  system clock, 50 MHz
uart_rst_p  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to send the message
periodic_en  in  1  level; 1 = auto-trigger every PERIOD_CYC cycles
msg_len  in  LEN_W  number of bytes to send; sampled at trigger
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  buffer write address
wr_data  in  DATA_W  buffer write data
tx_done  in  1  one-cycle pulse from uart_txd: byte finished
uart_tx_enable  out  1  one-cycle pulse to uart_txd: start a byte
para_data  out  DATA_W  byte presented to uart_txd; stable from LOAD until the next LOAD
busy  out  1  high from trigger acceptance until return to IDLE
msg_done  out  1  one-cycle pulse: all bytes sent
overrun  out  1  one-cycle pulse: trigger arrived while busy and was dropped
tx_err  out  1  one-cycle pulse: tx_done timeout, message aborted
wr_err  out  1  one-cycle pulse: write attempted while busy and was ignored

Behaviour:
- Reset values: all outputs 0, para_data 0, FSM in IDLE, idx 0, period and timeout counters 0. Buffer contents are not reset.
- Trigger sources:
  - trig = start OR period tick.
  - Period tick: when periodic_en=1, the counter runs 0..PERIOD_CYC-1 and ticks on reaching PERIOD_CYC-1, then wraps to 0.
  - periodic_en=0 holds the counter at 0.
  - The counter keeps running while busy.
- FSM states: IDLE, LOAD, FIRE, WAIT, DONE.
- IDLE:
  - trig with eff_len != 0: latch eff_len = min(msg_len, DEPTH), set idx=0, busy=1, go to LOAD.
  - trig with eff_len == 0: ignored, no outputs.
- LOAD: para_data <= buf[idx] (registered read); go to FIRE.
- FIRE: uart_tx_enable=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - tx_done with idx == eff_len-1: go to DONE.
  - tx_done otherwise: idx+1, go to LOAD.
  - Timeout counter reaches TIMEOUT_CYC-1 with no tx_done: tx_err pulse, busy=0, go to IDLE.
- DONE: msg_done pulse, busy=0, go to IDLE.
- Latency:
  - trig to first uart_tx_enable: 2 cycles.
  - tx_done to next uart_tx_enable: 2 cycles.
  - Final tx_done to msg_done: 1 cycle.
- Simultaneous events:
  - start and period tick in the same cycle count as one trigger.
  - A trig seen in any state other than IDLE produces an overrun pulse and is otherwise dropped. This includes the DONE cycle.
- Buffer writes:
  - wr_en in IDLE writes buf[wr_addr] on the clock edge.
  - wr_en while busy=1 is ignored and pulses wr_err.
  - A write and a trigger in the same IDLE cycle: the write lands first. The new data is sent.
- tx_done outside WAIT is ignored.
- msg_len changes while busy have no effect on the current message (eff_len is latched).
- Reset mid-message: immediate return to IDLE with outputs 0. No partial completion pulse is emitted.

Decomposition:
- Package uart_msg_pkg holds:
  - FSM state encoding (IDLE, LOAD, FIRE, WAIT, DONE);
  - default constants CLK_HZ=50_000_000, DEF_PERIOD_CYC, DEF_TIMEOUT_CYC.
- One natural sub-module: uart_msg_buf, a DEPTH x DATA_W single-write, registered-read buffer with the busy write guard.
- FSM, counters and handshake stay in uart_msg_sender.

Test Plan:
- Load "Hello World!\n" (13 bytes) into addresses 0..12, msg_len=13, pulse start, model tx_done 10 cycles after each enable -> 13 enables with para_data 0x48, 0x65, ... 0x0A in order; msg_done once, 1 cycle after the 13th tx_done; busy then 0.
- periodic_en=1, PERIOD_CYC=100, msg_len=2 -> a message starts every 100 cycles; first uart_tx_enable 2 cycles after each tick; no overrun.
- start pulsed while busy; msg_len=20 with DEPTH=16 -> overrun pulse, current message unaffected; in a separate run with msg_len=20, exactly 16 bytes are sent.
- tx_done withheld after byte 3, TIMEOUT_CYC=50 -> tx_err 50 cycles after the 3rd enable, busy=0, no msg_done; the next start sends from byte 0.
- wr_en to addr 5 while busy -> wr_err pulse, buf[5] unchanged; msg_len=0 with start -> no activity.
- Assert uart_rst_p during WAIT -> all outputs 0 immediately; FSM in IDLE; buffer contents intact on the next send.
